pairhmm_work_dispatcher: RTL and testbench
==========================================

# pairhmm_work_dispatcher

Parametrised dispatcher that takes packed PairHMM work requests from the host-side request stream, buffers them, and hands each one to one of `NUM_CHANNELS` PairHMM compute cores. It tracks the in-flight requests per core with credit counters and offers a round-robin or least-loaded selection policy. It sits between the request fetch logic and the core array, replacing a fixed single-core hookup.

## Interface

Parameters:
- `NUM_CHANNELS`, default 4: number of compute cores; must be 2 to 16.
- `REQ_WIDTH`, default 128: width of a packed work request (read addr/len, hap addr/len, initial condition, id).
- `FIFO_DEPTH`, default 16: input FIFO depth; must be a power of two and at least 2.
- `MAX_OUTSTANDING`, default 2: maximum handshaked-but-not-done requests per channel; must be 1 to 15.

Ports. One clock; reset is asynchronous and active-low.
- `clk_main_a0`, in, 1: clock.
- `rst_main_n`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: request offered.
- `in_ready`, out, 1: FIFO can accept.
- `in_req`, in, `REQ_WIDTH`: packed request.
- `policy`, in, 1: selection policy; 0 = round-robin, 1 = least-loaded.
- `ch_valid`, out, `NUM_CHANNELS`: per-channel valid; at most one bit set.
- `ch_ready`, in, `NUM_CHANNELS`: per-channel ready.
- `ch_req`, out, `REQ_WIDTH`: request bus shared by all channels.
- `ch_done`, in, `NUM_CHANNELS`: one-cycle pulse per completed request.
- `fifo_count`, out, `$clog2(FIFO_DEPTH)+1`: FIFO occupancy.
- `outstanding_total`, out, 8: sum of all channel credit counters.
- `idle`, out, 1: all work drained.
- `err_underflow`, out, 1: sticky flag for a done pulse on a channel with no outstanding request.

## Operation

Input FIFO:
- A push happens when `in_valid` and `in_ready` are both high.
- `in_ready` is registered: `in_ready` = !full.
- There is no push/pop bypass. When the FIFO is full, `in_ready` stays low even in a cycle where a pop occurs.

Output stage, two states:
- **EMPTY**: `ch_valid` = 0.
- **HOLD**: exactly one bit k of `ch_valid` is set, and `ch_req` carries the request.
- EMPTY → HOLD when the FIFO is non-empty and at least one channel is eligible. On this transition the FIFO head is popped into the output register.
- HOLD → EMPTY on `ch_valid[k]` & `ch_ready[k]`, unless a new load happens in the same cycle, in which case the stage stays in HOLD. Back-to-back handshakes give one request per cycle.
- In HOLD, `ch_req` and `ch_valid` stay stable until the handshake.

Credits:
- `out_cnt[i]`, width 4. It increments on a handshake on channel i and decrements on `ch_done[i]`. When both occur in the same cycle the count is unchanged.
- A `ch_done[i]` pulse when `out_cnt[i]` = 0 and there is no same-cycle handshake: the counter stays at 0 and `err_underflow` sets. `err_underflow` clears only on reset.

Eligibility:
- Channel i is eligible when `cnt_next[i]` < `MAX_OUTSTANDING`.
- `cnt_next` is the counter value after this cycle's handshake and done updates.

Selection at load time:
- Round-robin: choose the first eligible channel scanning `rr_ptr`, `rr_ptr`+1, … modulo `NUM_CHANNELS`. After a load to channel k, `rr_ptr` ← (k+1) mod `NUM_CHANNELS`.
- Least-loaded: choose the eligible channel with the smallest `cnt_next`; ties go to the lowest index.
- `rr_ptr` updates on every load in both policies.
- `policy` is sampled at each load, so a change applies from the next selection.
- If no channel is eligible, the head stays in the FIFO and the stage stays in EMPTY.

Status outputs:
- `idle` = FIFO empty & stage EMPTY & `outstanding_total` = 0. It is registered.
- `fifo_count` and `outstanding_total` are registered and reflect the state after the previous edge.

## Timing

- Reset, asynchronous: FIFO pointers, `rr_ptr`, all `out_cnt` and `err_underflow` go to 0, and the stage goes to EMPTY. Outputs take these values:
  - `in_ready` = 0
  - `ch_valid` = 0
  - `ch_req` = 0
  - `fifo_count` = 0
  - `outstanding_total` = 0
  - `idle` = 0
- At the first edge after reset release, `in_ready` goes to 1 and `idle` goes to 1.
- Latency: a request pushed at edge t is in the FIFO at t+1, is loaded at edge t+1, and shows `ch_valid` high in the cycle after t+1. That is a minimum of 2 edges from push to presentation.
- FIFO pointers wrap modulo `FIFO_DEPTH`; the count distinguishes full from empty.
- Reset mid-operation: in-flight requests are discarded, and `ch_done` pulses arriving after reset count as underflow.
- Simultaneous push and pop with the FIFO neither full nor empty: the count is unchanged.

## Test plan

- **Reset values.** Assert reset mid-stream with the FIFO holding 5 requests. Required:
  - during reset: all outputs 0;
  - one edge after release: `in_ready` = 1, `idle` = 1, `fifo_count` = 0.
- **Round-robin.** `NUM_CHANNELS` = 4, all `ch_ready` = 1, no done pulses, `MAX_OUTSTANDING` = 2, 8 requests pushed back-to-back. Required: the channel order is 0,1,2,3,0,1,2,3, then the stage stalls in EMPTY with `outstanding_total` = 8.
- **Least-loaded.** Preload counts 2,1,0,1, with `MAX_OUTSTANDING` = 3 and `policy` = 1. Required: the next request goes to channel 2, and the following one goes to channel 1 (tie at count 1, lowest index).
- **Credit edge.** Channel 0 at `MAX_OUTSTANDING`, all others ineligible, `ch_done[0]` pulsed in the same cycle as a pending load. Required: a load to channel 0 happens that cycle and `out_cnt[0]` is unchanged net.
- **Full FIFO.** Hold `ch_ready` = 0 and push 17 requests with `FIFO_DEPTH` = 16. Required: `in_ready` drops after 16 entries plus 1 load, `fifo_count` = 16, and no request is lost. When drained, the requests come out in push order.
- **Underflow.** Pulse `ch_done[3]` with `out_cnt[3]` = 0. Required: `err_underflow` = 1 and stays set, and `out_cnt[3]` = 0.

Source files
------------

// File: rtl/pairhmm_work_dispatcher.sv
// Dispatches buffered PairHMM work requests to one of NUM_CHANNELS compute cores,
// tracking per-core in-flight credits and choosing cores round-robin or least-loaded.
module pairhmm_work_dispatcher #(
  parameter int NUM_CHANNELS    = 4,
  parameter int REQ_WIDTH       = 128,
  parameter int FIFO_DEPTH      = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                          clk_main_a0,
  input  logic                          rst_main_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [REQ_WIDTH-1:0]          in_req,
  input  logic                          policy,
  output logic [NUM_CHANNELS-1:0]       ch_valid,
  input  logic [NUM_CHANNELS-1:0]       ch_ready,
  output logic [REQ_WIDTH-1:0]          ch_req,
  input  logic [NUM_CHANNELS-1:0]       ch_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    outstanding_total,
  output logic                          idle,
  output logic                          err_underflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int CHW = $clog2(NUM_CHANNELS);
  localparam logic [3:0] C_MAX = 4'(MAX_OUTSTANDING);

  typedef enum logic {ST_EMPTY, ST_HOLD} state_t;

  state_t                  r_state, w_state_next;
  logic [REQ_WIDTH-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_count, w_count_next;
  logic                    r_in_ready;
  logic [CHW-1:0]          r_ch, r_rr;
  logic [REQ_WIDTH-1:0]    r_req;
  logic [3:0]              r_cnt [NUM_CHANNELS];
  logic [3:0]              w_cnt_next [NUM_CHANNELS];
  logic                    r_err, r_idle;
  logic [7:0]              r_total, w_total_next;

  logic                    w_push, w_hs, w_load, w_uflow;
  logic [NUM_CHANNELS-1:0] w_inc, w_elig;
  logic [CHW-1:0]          w_rr_sel, w_ll_sel, w_sel;
  logic [3:0]              w_best;

  assign w_push = in_valid & r_in_ready;
  assign w_hs   = (r_state == ST_HOLD) && ch_ready[r_ch];
  assign w_inc  = w_hs ? (NUM_CHANNELS'(1) << r_ch) : '0;

  // A done with no credit and no same-cycle handshake clamps at zero and flags underflow.
  always_comb begin
    w_uflow = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (w_inc[i] && !ch_done[i]) begin
        w_cnt_next[i] = r_cnt[i] + 4'd1;
      end else if (!w_inc[i] && ch_done[i]) begin
        if (r_cnt[i] == 4'd0) w_uflow = 1'b1;
        else                  w_cnt_next[i] = r_cnt[i] - 4'd1;
      end
      w_elig[i] = (w_cnt_next[i] < C_MAX);
    end
  end

  always_comb begin
    w_rr_sel = '0;
    for (int off = NUM_CHANNELS - 1; off >= 0; off--) begin
      if (w_elig[(int'(r_rr) + off) % NUM_CHANNELS])
        w_rr_sel = CHW'((int'(r_rr) + off) % NUM_CHANNELS);
    end
    // Strict less-than keeps the lowest index on ties.
    w_ll_sel = '0;
    w_best   = 4'hF;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (w_elig[i] && (w_cnt_next[i] < w_best)) begin
        w_best   = w_cnt_next[i];
        w_ll_sel = CHW'(i);
      end
    end
  end

  assign w_sel  = policy ? w_ll_sel : w_rr_sel;
  assign w_load = (r_count != '0) && (|w_elig) && ((r_state == ST_EMPTY) || w_hs);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_load);

  always_comb begin
    w_total_next = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_total_next = w_total_next + 8'(w_cnt_next[i]);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_load) w_state_next = ST_HOLD;
      ST_HOLD:  if (!w_load && w_hs) w_state_next = ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_main_a0) begin
    if (w_push) r_mem[r_wr_ptr] <= in_req;
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
      r_state    <= ST_EMPTY;
      r_ch       <= '0;
      r_req      <= '0;
      r_rr       <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) r_cnt[i] <= '0;
      r_err      <= 1'b0;
      r_total    <= '0;
      r_idle     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != CW'(FIFO_DEPTH));
      r_state    <= w_state_next;
      if (w_load) begin
        r_ch  <= w_sel;
        r_req <= r_mem[r_rd_ptr];
        r_rr  <= (w_sel == CHW'(NUM_CHANNELS - 1)) ? '0 : w_sel + CHW'(1);
      end
      for (int i = 0; i < NUM_CHANNELS; i++) r_cnt[i] <= w_cnt_next[i];
      if (w_uflow) r_err <= 1'b1;
      r_total    <= w_total_next;
      r_idle     <= (w_count_next == '0) && (w_state_next == ST_EMPTY) && (w_total_next == '0);
    end
  end

  assign in_ready          = r_in_ready;
  assign ch_valid          = (r_state == ST_HOLD) ? (NUM_CHANNELS'(1) << r_ch) : '0;
  assign ch_req            = r_req;
  assign fifo_count        = r_count;
  assign outstanding_total = r_total;
  assign idle              = r_idle;
  assign err_underflow     = r_err;

endmodule

// File: tb/tb_pairhmm_work_dispatcher.sv
// Self-checking bench for pairhmm_work_dispatcher: directed scenarios plus random
// traffic, all compared against a queue-based reference model of the dispatcher.
module tb_pairhmm_work_dispatcher;

  localparam int N    = 4;
  localparam int W    = 128;
  localparam int D    = 16;
  localparam int MAXO = 2;

  logic           clk = 1'b0;
  logic           rstN = 1'b1;
  logic           inValid = 1'b0;
  logic [W-1:0]   inReq = '0;
  logic           policy = 1'b0;
  logic [N-1:0]   chReady = '0;
  logic [N-1:0]   chDone = '0;
  logic           in_ready;
  logic [N-1:0]   ch_valid;
  logic [W-1:0]   ch_req;
  logic [4:0]     fifo_count;
  logic [7:0]     outstanding_total;
  logic           idle;
  logic           err_underflow;

  int testsRun = 0;
  int testsFailed = 0;

  // reference model state
  logic [W-1:0] mq[$];
  bit           mInReady, mHold, mErr, mIdle;
  int           mCh, mRr;
  int           mCnt [N];
  logic [W-1:0] mReq;

  // observation records for directed order checks
  bit           recOn = 1'b0;
  int           obsCh[$];
  logic [W-1:0] obsReq[$];
  logic [W-1:0] pushedList[$];

  pairhmm_work_dispatcher #(
    .NUM_CHANNELS(N), .REQ_WIDTH(W), .FIFO_DEPTH(D), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_main_a0(clk), .rst_main_n(rstN),
    .in_valid(inValid), .in_ready(in_ready), .in_req(inReq), .policy(policy),
    .ch_valid(ch_valid), .ch_ready(chReady), .ch_req(ch_req), .ch_done(chDone),
    .fifo_count(fifo_count), .outstanding_total(outstanding_total),
    .idle(idle), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [W-1:0] randReq();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [N-1:0] busyMask();
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) if (mCnt[i] > 0) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    mq.delete();
    mInReady = 0; mHold = 0; mErr = 0; mIdle = 0;
    mCh = 0; mRr = 0; mReq = '0;
    for (int i = 0; i < N; i++) mCnt[i] = 0;
  endtask

  // One clock edge of the dispatcher, described in terms of credits and queues.
  task automatic modelStep();
    bit hs, anyElig, load;
    int cn [N];
    int k, j, sum;
    hs = mHold && chReady[mCh];
    for (int i = 0; i < N; i++) begin
      cn[i] = mCnt[i] + ((hs && mCh == i) ? 1 : 0) - (chDone[i] ? 1 : 0);
      if (cn[i] < 0) begin cn[i] = 0; mErr = 1; end
    end
    anyElig = 0;
    for (int i = 0; i < N; i++) if (cn[i] < MAXO) anyElig = 1;
    load = (mq.size() > 0) && anyElig && (!mHold || hs);
    if (load) begin
      k = -1;
      if (policy) begin
        for (int i = 0; i < N; i++)
          if (cn[i] < MAXO && (k < 0 || cn[i] < cn[k])) k = i;
      end else begin
        for (int off = 0; off < N; off++) begin
          j = (mRr + off) % N;
          if (k < 0 && cn[j] < MAXO) k = j;
        end
      end
      mReq  = mq.pop_front();
      mCh   = k;
      mHold = 1;
      mRr   = (k + 1) % N;
    end else if (hs) begin
      mHold = 0;
    end
    if (inValid && mInReady) mq.push_back(inReq);
    sum = 0;
    for (int i = 0; i < N; i++) begin mCnt[i] = cn[i]; sum += cn[i]; end
    mInReady = (mq.size() != D);
    mIdle    = (mq.size() == 0) && !mHold && (sum == 0);
  endtask

  task automatic checkOutput();
    logic [N-1:0] expValid;
    int sum, idx;
    expValid = mHold ? (N'(1) << mCh) : '0;
    sum = 0;
    for (int i = 0; i < N; i++) sum += mCnt[i];
    check("in_ready", W'(in_ready), W'(mInReady));
    check("ch_valid", W'(ch_valid), W'(expValid));
    if (mHold) check("ch_req", ch_req, mReq);
    check("fifo_count", W'(fifo_count), W'(mq.size()));
    check("outstanding_total", W'(outstanding_total), W'(sum));
    check("idle", W'(idle), W'(mIdle));
    check("err_underflow", W'(err_underflow), W'(mErr));
    if (recOn && ch_valid != '0) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (ch_valid[i]) idx = i;
      obsCh.push_back(idx);
      obsReq.push_back(ch_req);
    end
  endtask

  // Called at a falling edge: drive inputs, advance the model, check after the next edge.
  task automatic applyStimulus(input logic v, input logic [W-1:0] r, input logic [N-1:0] rdy,
                               input logic [N-1:0] dn, input logic pol);
    inValid = v; inReq = r; chReady = rdy; chDone = dn; policy = pol;
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    inValid = 0; chDone = '0; chReady = '0;
    rstN = 1'b0;
    #1;
    modelClear();
    check("rst_in_ready", W'(in_ready), '0);
    check("rst_ch_valid", W'(ch_valid), '0);
    check("rst_ch_req", ch_req, '0);
    check("rst_fifo_count", W'(fifo_count), '0);
    check("rst_outstanding", W'(outstanding_total), '0);
    check("rst_idle", W'(idle), '0);
    check("rst_err", W'(err_underflow), '0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(0, '0, '0, '0, 0);
    check("rel_in_ready", W'(in_ready), W'(1));
    check("rel_idle", W'(idle), W'(1));
    check("rel_fifo_count", W'(fifo_count), '0);
  endtask

  initial begin
    int acc;
    logic v;
    logic [W-1:0] r;
    logic [N-1:0] dn;
    modelClear();
    @(negedge clk);
    doReset();

    // round-robin until every channel holds MAXO credits
    recOn = 1; obsCh.delete(); obsReq.delete();
    for (int i = 0; i < 8; i++) applyStimulus(1, randReq(), '1, '0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, '0, '1, '0, 0);
    recOn = 0;
    check("rr_count", W'(obsCh.size()), W'(8));
    for (int i = 0; i < obsCh.size() && i < 8; i++) check("rr_order", W'(obsCh[i]), W'(i % N));
    check("rr_total", W'(outstanding_total), W'(8));
    check("rr_stall", W'(ch_valid), '0);

    applyStimulus(0, '0, '1, '1, 0);
    applyStimulus(0, '0, '1, '1, 0);
    check("drain_idle", W'(idle), W'(1));

    // least-loaded with counts 1,1,0,1 and rr pointer at 0
    for (int i = 0; i < 4; i++) applyStimulus(1, randReq(), '1, '0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, '0, '1, '0, 0);
    applyStimulus(0, '0, '1, 4'b0100, 0);
    recOn = 1; obsCh.delete(); obsReq.delete();
    applyStimulus(1, randReq(), '1, '0, 1);
    applyStimulus(1, randReq(), '1, '0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, '0, '1, '0, 1);
    recOn = 0;
    check("ll_count", W'(obsCh.size()), W'(2));
    if (obsCh.size() >= 2) begin
      check("ll_first", W'(obsCh[0]), W'(2));
      check("ll_tie", W'(obsCh[1]), W'(0));
    end

    // credit edge: all channels saturated, a done on channel 0 frees it for a pending load
    for (int i = 0; i < 3; i++) applyStimulus(1, randReq(), '1, '0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, '1, '0, 1);
    applyStimulus(1, randReq(), '1, '0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, '1, '0, 1);
    check("edge_stalled", W'(ch_valid), '0);
    check("edge_fifo", W'(fifo_count), W'(1));
    applyStimulus(0, '0, '1, 4'b0001, 1);
    check("edge_load_ch0", W'(ch_valid), W'(4'b0001));
    applyStimulus(0, '0, '1, '0, 1);
    check("edge_total", W'(outstanding_total), W'(8));
    applyStimulus(0, '0, '1, '1, 0);
    applyStimulus(0, '0, '1, '1, 0);

    // full FIFO with cores stalled, then drain in order
    acc = 0; pushedList.delete();
    for (int c = 0; c < 22; c++) begin
      v = (acc < 17);
      r = randReq();
      if (v && mInReady) begin pushedList.push_back(r); acc++; end
      applyStimulus(v, r, '0, '0, 0);
    end
    check("full_in_ready", W'(in_ready), '0);
    check("full_count", W'(fifo_count), W'(16));
    check("full_held", W'(ch_valid != '0), W'(1));
    obsCh.delete(); obsReq.delete();
    obsReq.push_back(ch_req);
    recOn = 1;
    for (int c = 0; c < 60; c++) applyStimulus(0, '0, '1, busyMask(), 0);
    recOn = 0;
    check("drain_count", W'(obsReq.size()), W'(17));
    for (int i = 0; i < obsReq.size() && i < pushedList.size(); i++)
      check("drain_order", obsReq[i], pushedList[i]);
    check("drain_total", W'(outstanding_total), '0);

    // underflow on an idle channel
    check("pre_uflow_err", W'(err_underflow), '0);
    applyStimulus(0, '0, '1, 4'b1000, 0);
    check("uflow_err", W'(err_underflow), W'(1));
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, '1, '0, 0);
    check("uflow_sticky", W'(err_underflow), W'(1));
    check("uflow_total", W'(outstanding_total), '0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      dn = N'($urandom()) & busyMask();
      if ($urandom_range(0, 15) == 0) dn = N'($urandom());
      applyStimulus(1'($urandom_range(0, 1)), randReq(), N'($urandom()), dn, 1'($urandom_range(0, 1)));
    end

    // mid-stream reset with five requests queued
    for (int c = 0; c < 40; c++) applyStimulus(0, '0, '1, busyMask(), 0);
    for (int c = 0; c < 20; c++) begin
      v = ((mq.size() + (mHold ? 1 : 0)) < 6);
      applyStimulus(v, randReq(), '0, '0, 0);
    end
    check("mid_fifo", W'(fifo_count), W'(5));
    doReset();
    applyStimulus(0, '0, '0, 4'b0010, 0);
    check("post_rst_uflow", W'(err_underflow), W'(1));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
